// File: rtl/pipe_stage_fifo.sv
// ---------------------------------------------------------------------------
// pipe_stage_fifo
//   Valid/ready buffer between two pipeline stages. Holds up to DEPTH packed
//   payloads in a circular buffer. An optional bypass lets a beat pass
//   straight through when the buffer is empty. A synchronous flush discards
//   everything in flight when the core redirects.
//
// Parameters
//   WIDTH   payload width in bits (>= 1)
//   DEPTH   number of storage entries (>= 1, any value, not only powers of 2)
//   BYPASS  1 = combinational pass-through when empty, 0 = always registered
//
// Ports
//   i_clk      clock, all state updates on the rising edge
//   i_rst_n    asynchronous active-low reset (clears pointers and count)
//   i_flush    synchronous drop of all stored entries
//   i_s_valid  upstream payload valid
//   o_s_ready  space available (~full), does not depend on i_m_ready
//   i_s_data   upstream payload
//   o_m_valid  payload available downstream
//   i_m_ready  downstream accepts
//   o_m_data   downstream payload, oldest entry first
//   o_count    number of entries currently stored
// ---------------------------------------------------------------------------
module pipe_stage_fifo #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter bit BYPASS = 1'b0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_s_valid,
    output logic                       o_s_ready,
    input  logic [WIDTH-1:0]           i_s_data,
    output logic                       o_m_valid,
    input  logic                       i_m_ready,
    output logic [WIDTH-1:0]           o_m_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Bypass path is live only when nothing is stored, so ordering is kept.
    assign w_bypass = BYPASS && w_empty;

    // s_ready comes from count alone: no combinational m_ready -> s_ready path.
    assign o_s_ready = ~w_full;

    // In bypass the valid is gated by reset and flush so that nothing escapes
    // downstream while the buffer is being cleared.
    assign o_m_valid = w_bypass ? (i_s_valid & ~i_flush & i_rst_n) : ~w_empty;
    assign o_m_data  = w_bypass ? i_s_data : r_mem[r_rd_ptr];

    // A bypassed beat taken by the consumer in the same cycle is never written.
    assign w_push = i_s_valid & o_s_ready & ~(w_bypass & i_m_ready);
    // Pops are counted only when the beat is served from storage.
    assign w_pop  = ~w_empty & i_m_ready;

    assign o_count = r_count;

    // NOTE: payload storage has no reset; only pointers and count define which
    // entries are meaningful, so clearing the array would only add reset fan-out.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_s_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_fifo
//   Directed bench for pipe_stage_fifo. Three instances share clock and reset:
//     u_d2  DEPTH=2, BYPASS=0  (reset, streaming, async reset mid-stream)
//     u_d3  DEPTH=3, BYPASS=0  (backpressure with pointer wrap, flush)
//     u_byp DEPTH=2, BYPASS=1  (same-cycle bypass, order, flush gating)
//   Inputs change 1 ns after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_pipe_stage_fifo;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // u_d2 signals
    logic         a_flush, a_sv, a_sr, a_mv, a_mr;
    logic [W-1:0] a_sd, a_md;
    logic [1:0]   a_cnt;
    // u_d3 signals
    logic         b_flush, b_sv, b_sr, b_mv, b_mr;
    logic [W-1:0] b_sd, b_md;
    logic [1:0]   b_cnt;
    // u_byp signals
    logic         c_flush, c_sv, c_sr, c_mv, c_mr;
    logic [W-1:0] c_sd, c_md;
    logic [1:0]   c_cnt;

    pipe_stage_fifo #(.WIDTH(W), .DEPTH(2), .BYPASS(1'b0)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(a_flush),
        .i_s_valid(a_sv), .o_s_ready(a_sr), .i_s_data(a_sd),
        .o_m_valid(a_mv), .i_m_ready(a_mr), .o_m_data(a_md), .o_count(a_cnt)
    );

    pipe_stage_fifo #(.WIDTH(W), .DEPTH(3), .BYPASS(1'b0)) u_d3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(b_flush),
        .i_s_valid(b_sv), .o_s_ready(b_sr), .i_s_data(b_sd),
        .o_m_valid(b_mv), .i_m_ready(b_mr), .o_m_data(b_md), .o_count(b_cnt)
    );

    pipe_stage_fifo #(.WIDTH(W), .DEPTH(2), .BYPASS(1'b1)) u_byp (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(c_flush),
        .i_s_valid(c_sv), .o_s_ready(c_sr), .i_s_data(c_sd),
        .o_m_valid(c_mv), .i_m_ready(c_mr), .o_m_data(c_md), .o_count(c_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        a_flush = 1'b0; a_sv = 1'b1; a_sd = 32'hDEAD; a_mr = 1'b1;
        b_flush = 1'b0; b_sv = 1'b0; b_sd = '0;       b_mr = 1'b0;
        c_flush = 1'b0; c_sv = 1'b1; c_sd = 32'hBEEF; c_mr = 1'b1;

        // ---- reset held with s_valid=1 ----
        #1;
        check("rst_mv", {31'd0, a_mv}, 32'd0);
        check("rst_sr", {31'd0, a_sr}, 32'd1);
        check("rst_cnt", {30'd0, a_cnt}, 32'd0);
        check("rst_byp_mv", {31'd0, c_mv}, 32'd0);
        step();
        step();
        check("rst_mv_hold", {31'd0, a_mv}, 32'd0);
        check("rst_cnt_hold", {30'd0, a_cnt}, 32'd0);
        check("rst_byp_mv_hold", {31'd0, c_mv}, 32'd0);

        // ---- release, first push at edge 1, visible in cycle 2 ----
        rst_n = 1'b1;
        c_sv  = 1'b0;
        a_sv  = 1'b1; a_sd = 32'h11; a_mr = 1'b0;
        check("first_pre_mv", {31'd0, a_mv}, 32'd0);
        step();
        check("first_mv", {31'd0, a_mv}, 32'd1);
        check("first_md", a_md, 32'h11);
        check("first_cnt", {30'd0, a_cnt}, 32'd1);
        a_sv = 1'b0; a_mr = 1'b1;
        step();
        check("first_drain_mv", {31'd0, a_mv}, 32'd0);

        // ---- streaming 1..8, DEPTH=2, m_ready=1 ----
        for (int i = 1; i <= 8; i++) begin
            a_sv = 1'b1; a_sd = 32'(i);
            step();
            check("strm_mv", {31'd0, a_mv}, 32'd1);
            check("strm_md", a_md, 32'(i));
            check("strm_cnt", {30'd0, a_cnt}, 32'd1);
        end
        a_sv = 1'b0;
        step();
        check("strm_end_mv", {31'd0, a_mv}, 32'd0);
        check("strm_end_cnt", {30'd0, a_cnt}, 32'd0);

        // ---- backpressure, DEPTH=3 ----
        b_mr = 1'b0;
        b_sv = 1'b1; b_sd = 32'hA; check("bp_sr_a", {31'd0, b_sr}, 32'd1); step();
        b_sd = 32'hB;              check("bp_sr_b", {31'd0, b_sr}, 32'd1); step();
        b_sd = 32'hC;              check("bp_sr_c", {31'd0, b_sr}, 32'd1); step();
        check("bp_full_cnt", {30'd0, b_cnt}, 32'd3);
        b_sd = 32'hD;
        check("bp_full_sr", {31'd0, b_sr}, 32'd0);
        step();
        check("bp_hold_cnt", {30'd0, b_cnt}, 32'd3);
        check("bp_hold_md", b_md, 32'hA);
        b_mr = 1'b1;
        step();
        check("bp_out_b", b_md, 32'hB);
        check("bp_cnt_2a", {30'd0, b_cnt}, 32'd2);
        step();
        b_sv = 1'b0;
        check("bp_out_c", b_md, 32'hC);
        check("bp_cnt_2b", {30'd0, b_cnt}, 32'd2);
        step();
        check("bp_out_d_wrap", b_md, 32'hD);
        check("bp_cnt_1", {30'd0, b_cnt}, 32'd1);
        step();
        check("bp_empty_mv", {31'd0, b_mv}, 32'd0);
        check("bp_empty_cnt", {30'd0, b_cnt}, 32'd0);

        // ---- flush with count=2, DEPTH=3 ----
        b_mr = 1'b0;
        b_sv = 1'b1; b_sd = 32'h21; step();
        b_sd = 32'h22; step();
        check("fl_pre_cnt", {30'd0, b_cnt}, 32'd2);
        b_flush = 1'b1; b_sd = 32'h55; b_mr = 1'b1;
        step();
        b_flush = 1'b0; b_sv = 1'b0;
        check("fl_cnt", {30'd0, b_cnt}, 32'd0);
        check("fl_mv", {31'd0, b_mv}, 32'd0);
        step();
        check("fl_no55_mv", {31'd0, b_mv}, 32'd0);
        b_sv = 1'b1; b_sd = 32'h66;
        step();
        b_sv = 1'b0;
        check("fl_after_md", b_md, 32'h66);
        check("fl_after_cnt", {30'd0, b_cnt}, 32'd1);
        step();
        check("fl_after_drain", {31'd0, b_mv}, 32'd0);

        // ---- bypass, empty, m_ready=1 ----
        c_sv = 1'b1; c_sd = 32'h77; c_mr = 1'b1;
        #1;
        check("byp_mv", {31'd0, c_mv}, 32'd1);
        check("byp_md", c_md, 32'h77);
        check("byp_cnt", {30'd0, c_cnt}, 32'd0);
        step();
        check("byp_cnt_after", {30'd0, c_cnt}, 32'd0);
        // ---- bypass, empty, m_ready=0 -> stored ----
        c_mr = 1'b0;
        step();
        c_sv = 1'b0;
        check("byp_st_cnt", {30'd0, c_cnt}, 32'd1);
        check("byp_st_mv", {31'd0, c_mv}, 32'd1);
        check("byp_st_md", c_md, 32'h77);
        c_mr = 1'b1;
        step();
        check("byp_st_drain_cnt", {30'd0, c_cnt}, 32'd0);
        check("byp_st_drain_mv", {31'd0, c_mv}, 32'd0);
        // ---- bypass, not empty: order kept ----
        c_mr = 1'b0; c_sv = 1'b1; c_sd = 32'h01;
        step();
        c_sd = 32'h02;
        #1;
        check("byp_order_md", c_md, 32'h01);
        step();
        c_sv = 1'b0; c_mr = 1'b1;
        check("byp_order_cnt", {30'd0, c_cnt}, 32'd2);
        step();
        check("byp_order_md2", c_md, 32'h02);
        step();
        // ---- bypass flush gating ----
        c_sv = 1'b1; c_sd = 32'h88; c_flush = 1'b1;
        #1;
        check("byp_fl_mv", {31'd0, c_mv}, 32'd0);
        step();
        c_flush = 1'b0; c_sv = 1'b0;
        check("byp_fl_cnt", {30'd0, c_cnt}, 32'd0);

        // ---- async reset mid-operation, DEPTH=2 ----
        a_mr = 1'b0;
        a_sv = 1'b1; a_sd = 32'h31; step();
        a_sd = 32'h32; step();
        a_sv = 1'b0;
        check("ar_pre_cnt", {30'd0, a_cnt}, 32'd2);
        check("ar_pre_mv", {31'd0, a_mv}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_mv", {31'd0, a_mv}, 32'd0);
        check("ar_cnt", {30'd0, a_cnt}, 32'd0);
        check("ar_sr", {31'd0, a_sr}, 32'd1);
        step();
        rst_n = 1'b1;
        a_mr  = 1'b1;
        check("ar_rel_mv", {31'd0, a_mv}, 32'd0);
        step();
        check("ar_no_stale", {31'd0, a_mv}, 32'd0);
        check("ar_no_stale_cnt", {30'd0, a_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
